// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, state encoding and helpers for the fetch controller
package fetch_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;
  typedef enum logic {WAIT, RUN} state_e;
  function automatic logic [31:0] align_word(logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_dbg_arb.sv
// fetch_dbg_arb: shares the single ROM port between fetch and debug, bounding debug starvation
module fetch_dbg_arb import fetch_pkg::*; #(
  parameter int STARVE_MAX = 3
) (
  input  logic   clk,
  input  logic   resetn,
  input  state_e state,
  input  logic   slot,
  input  logic   flush,
  input  logic   dbg_req,
  input  logic   ack_busy,
  output logic   dbg_gnt,
  output logic   fetch_gnt
);
  localparam int SW = $clog2(STARVE_MAX + 2);
  logic [SW-1:0] starve_q, starve_d;
  logic run;
  always_comb begin
    run = state == RUN;
    dbg_gnt = run && dbg_req && !ack_busy && (!slot || starve_q == SW'(STARVE_MAX));
    fetch_gnt = run && slot && !dbg_gnt && !flush;
    starve_d = (!dbg_req || dbg_gnt) ? '0 : fetch_gnt ? starve_q + SW'(1) : starve_q;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) starve_q <= '0;
    else starve_q <= starve_d;
  end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch with branch redirect, decode backpressure and debug ROM reads
module fetch_ctrl import fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          ROM_WORDS  = 20,
  parameter int          STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [4:0]  rom_addr,
  input  logic [31:0] rom_data,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        if_ready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        dbg_req,
  input  logic [4:0]  dbg_addr,
  output logic        dbg_ack,
  output logic [31:0] dbg_data,
  output logic        pc_err
);
  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d, inst_pc_q, inst_pc_d, dbg_data_q, dbg_data_d;
  logic inst_valid_q, inst_valid_d, dbg_ack_q, dbg_ack_d, pc_err_q, pc_err_d;
  logic slot, oob, dbg_gnt, fetch_gnt;
  assign slot = !inst_valid_q || if_ready;
  assign oob = pc_q[31:2] >= 30'(ROM_WORDS);
  fetch_dbg_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk      (clk),
    .resetn   (resetn),
    .state    (state_q),
    .slot     (slot),
    .flush    (br_taken),
    .dbg_req  (dbg_req),
    .ack_busy (dbg_ack_q),
    .dbg_gnt  (dbg_gnt),
    .fetch_gnt(fetch_gnt)
  );
  // A redirect squashes the fetch slot; a debug grant in the same cycle still completes.
  always_comb begin
    state_d = RUN;
    rom_addr = dbg_gnt ? dbg_addr : pc_q[6:2];
    pc_d = br_taken ? align_word(br_target) : fetch_gnt ? pc_q + 32'd4 : pc_q;
    inst_d = fetch_gnt ? (oob ? NOP : rom_data) : inst_q;
    inst_pc_d = fetch_gnt ? pc_q : inst_pc_q;
    inst_valid_d = br_taken ? 1'b0 : fetch_gnt ? 1'b1 : if_ready ? 1'b0 : inst_valid_q;
    dbg_ack_d = dbg_gnt;
    dbg_data_d = dbg_gnt ? rom_data : dbg_data_q;
    pc_err_d = pc_err_q || (fetch_gnt && oob);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= WAIT;
      pc_q <= RESET_PC;
      inst_q <= '0;
      inst_pc_q <= '0;
      inst_valid_q <= 1'b0;
      dbg_ack_q <= 1'b0;
      dbg_data_q <= '0;
      pc_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      inst_q <= inst_d;
      inst_pc_q <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      dbg_ack_q <= dbg_ack_d;
      dbg_data_q <= dbg_data_d;
      pc_err_q <= pc_err_d;
    end
  end
  assign inst_valid = inst_valid_q;
  assign inst = inst_q;
  assign inst_pc = inst_pc_q;
  assign dbg_ack = dbg_ack_q;
  assign dbg_data = dbg_data_q;
  assign pc_err = pc_err_q;
endmodule
